// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential converter from eight packed BCD digits to an unsigned
// binary value. It handles one digit per clock, most significant digit first.
// It uses a start/busy/done handshake, and a done pulse follows 8 clocks after
// start is accepted.
// Optional feature macro: BCD_TO_BIN_DIGIT_EN. When it is defined, an en[7:0]
// port is added. Digits whose enable bit is low count as 0 and are not checked
// for validity.
module bcd_to_bin #(
  parameter int W_BIN = 32
) (
  input  logic             clk_100kHz,
  input  logic             rst_,
  input  logic             start,
  input  logic [3:0]       bcd0,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd4,
  input  logic [3:0]       bcd5,
  input  logic [3:0]       bcd6,
  input  logic [3:0]       bcd7,
`ifdef BCD_TO_BIN_DIGIT_EN
  input  logic [7:0]       en,
`endif
  output logic [W_BIN-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t           state_reg;
  logic [31:0]      sr_reg;
  logic [W_BIN-1:0] acc_reg;
  logic [2:0]       cnt_reg;
  logic             bad_reg;
  logic [W_BIN-1:0] bin_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  logic [3:0]       digit_in [8];
  logic [7:0]       digit_used;
  logic [7:0]       digit_bad;
  logic [31:0]      sr_load;
  logic [W_BIN-1:0] acc_next;

  assign digit_in[0] = bcd0;
  assign digit_in[1] = bcd1;
  assign digit_in[2] = bcd2;
  assign digit_in[3] = bcd3;
  assign digit_in[4] = bcd4;
  assign digit_in[5] = bcd5;
  assign digit_in[6] = bcd6;
  assign digit_in[7] = bcd7;

`ifdef BCD_TO_BIN_DIGIT_EN
  assign digit_used = en;
`else
  assign digit_used = 8'hFF;
`endif

  // Per-digit masking and range check. A disabled digit loads as 0, which is
  // always valid, so it drops out of both the sum and the error flag.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    assign sr_load[gi*4 +: 4] = digit_used[gi] ? digit_in[gi] : 4'h0;
    assign digit_bad[gi]      = digit_used[gi] && (digit_in[gi] > 4'd9);
  end

  // acc*10 plus the current top digit. Shifts keep this free of a multiplier.
  assign acc_next = (acc_reg << 3) + (acc_reg << 1)
                  + {{(W_BIN-4){1'b0}}, sr_reg[31:28]};

  // Handshake FSM: latch the digits on start, then fold in one digit per edge.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      bad_reg   <= 1'b0;
      bin_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            sr_reg    <= sr_load;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            bad_reg   <= |digit_bad;
            busy_reg  <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          sr_reg  <= {sr_reg[27:0], 4'h0};
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            bin_reg   <= bad_reg ? '0 : acc_next;
            err_reg   <= bad_reg;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bin  = bin_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed and random conversions for bcd_to_bin. Each result
// is compared with an arithmetic model of BCD place values.
// The en checks run only when BCD_TO_BIN_DIGIT_EN is defined.
module tb_bcd_to_bin;

  localparam int W = 32;

  logic         clk_100kHz = 1'b0;
  logic         rst_;
  logic         start;
  logic [3:0]   bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7;
  logic [7:0]   en_tb = 8'hFF;
  logic [W-1:0] bin;
  logic         busy, done, err;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] prev_bin = '0;

  bcd_to_bin #(.W_BIN(W)) dut (
    .clk_100kHz (clk_100kHz),
    .rst_       (rst_),
    .start      (start),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .bcd2       (bcd2),
    .bcd3       (bcd3),
    .bcd4       (bcd4),
    .bcd5       (bcd5),
    .bcd6       (bcd6),
    .bcd7       (bcd7),
`ifdef BCD_TO_BIN_DIGIT_EN
    .en         (en_tb),
`endif
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk_100kHz = ~clk_100kHz;

  task automatic tick();
    @(posedge clk_100kHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // The nibble at bit position 4*i drives bcdi.
  task automatic set_digits(input logic [31:0] p);
    bcd0 = p[3:0];   bcd1 = p[7:4];   bcd2 = p[11:8];  bcd3 = p[15:12];
    bcd4 = p[19:16]; bcd5 = p[23:20]; bcd6 = p[27:24]; bcd7 = p[31:28];
  endtask

  // Reference model: sum of digit * 10^position over the enabled digits.
  // Any enabled digit above 9 gives err=1 and a result of 0.
  function automatic logic [W:0] model(input logic [31:0] p, input logic [7:0] e);
    longint val = 0;
    longint weight = 1;
    bit bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) begin
        if (p[i*4 +: 4] > 4'd9) bad = 1;
        val += longint'(p[i*4 +: 4]) * weight;
      end
      weight *= 10;
    end
    if (bad) return {1'b1, {W{1'b0}}};
    return {1'b0, W'(val)};
  endfunction

  // One full conversion with a one-cycle start pulse. The inputs are
  // scrambled after the latch edge, and the handshake is checked every cycle.
  task automatic run_conv(input logic [31:0] p, input string tag);
    logic [W:0] exp;
    exp = model(p, en_tb);
    set_digits(p);
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    set_digits($urandom);
    chk({tag, "_busy_after_E0"}, {63'd0, busy}, 64'd1);
    for (int k = 1; k <= 7; k++) begin
      tick();                                 // E1..E7
      chk({tag, "_mid_state"}, {62'd0, busy, done}, 64'd2);
      chk({tag, "_bin_stable"}, 64'(bin), 64'(prev_bin));
    end
    tick();                                   // E8
    chk({tag, "_done"}, {62'd0, done, busy}, 64'd2);
    chk({tag, "_bin"}, 64'(bin), 64'(exp[W-1:0]));
    chk({tag, "_err"}, {63'd0, err}, {63'd0, exp[W]});
    $display("conv %s digits=%08h bin=%0d err=%0b", tag, p, bin, err);
    tick();                                   // E9
    chk({tag, "_done_fall"}, {63'd0, done}, 64'd0);
    prev_bin = exp[W-1:0];
  endtask

  initial begin
    logic [31:0] pa, pb, pr;
    logic [W:0]  ea, eb;
    rst_  = 1'b0;
    start = 1'b0;
    set_digits(32'h0);
    #12;
    chk("reset_outputs", {31'd0, bin, busy, done, err}, 64'd0);
    #11 rst_ = 1'b1;
    tick();
    chk("idle_after_reset", {61'd0, busy, done, err}, 64'd0);

    // Directed cases
    run_conv(32'h12345678, "d12345678");
    chk("d12345678_const", 64'(bin), 64'd12345678);
    run_conv(32'h99999999, "all9");
    chk("all9_const", 64'(bin), 64'h05F5E0FF);
    run_conv(32'h00000000, "all0");
    run_conv(32'h0000A001, "bad_digit");
    chk("bad_digit_err", {63'd0, err}, 64'd1);
    run_conv(32'h00000042, "after_bad");
    chk("after_bad_const", {31'd0, bin, err}, {31'd0, 32'd42, 1'b0});

    // Random cases: mostly valid digits, with occasional digits A-F
    for (int n = 0; n < 24; n++) begin
      pr = '0;
      for (int i = 0; i < 8; i++)
        pr[i*4 +: 4] = ($urandom_range(3) == 0) ? 4'($urandom_range(15))
                                                : 4'($urandom_range(9));
      run_conv(pr, "random");
    end

    // start held high: the digits change before E3, and the restart at E9
    // uses the new digits
    pa = 32'h00112233;
    pb = 32'h98765432;
    ea = model(pa, en_tb);
    eb = model(pb, en_tb);
    set_digits(pa);
    start = 1'b1;
    tick();                                   // E0
    tick(); tick();                           // E1, E2
    set_digits(pb);
    repeat (6) tick();                        // E3..E8
    chk("held_first_done", {63'd0, done}, 64'd1);
    chk("held_first_bin", 64'(bin), 64'(ea[W-1:0]));
    $display("conv held_a digits=%08h bin=%0d err=%0b", pa, bin, err);
    tick();                                   // E9
    chk("held_restart", {62'd0, busy, done}, 64'd2);
    repeat (8) tick();                        // E10..E17
    chk("held_second_done", {63'd0, done}, 64'd1);
    chk("held_second_bin", 64'(bin), 64'(eb[W-1:0]));
    $display("conv held_b digits=%08h bin=%0d err=%0b", pb, bin, err);
    start = 1'b0;
    tick();
    chk("held_idle", {62'd0, busy, done}, 64'd0);
    prev_bin = eb[W-1:0];

    // Reset asserted at E4 of a conversion
    set_digits(32'h87654321);
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    repeat (4) tick();                        // E1..E4
    rst_ = 1'b0;
    #1;
    chk("rst_mid_outputs", {31'd0, bin, busy, done, err}, 64'd0);
    tick();
    #3 rst_ = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_no_done", {62'd0, busy, done}, 64'd0);
    end
    prev_bin = '0;
    run_conv(32'h87654321, "after_reset");

`ifdef BCD_TO_BIN_DIGIT_EN
    en_tb = 8'h0F;
    run_conv(32'h99991234, "en_0F");
    chk("en_0F_const", {31'd0, bin, err}, {31'd0, 32'd1234, 1'b0});
    en_tb = 8'hFF;
    run_conv(32'hF0000001, "en_FF_bad");
    chk("en_FF_bad_err", {63'd0, err}, 64'd1);
    en_tb = 8'h7F;
    run_conv(32'hF0000001, "en_7F_masked");
    chk("en_7F_masked_err", {63'd0, err}, 64'd0);
    en_tb = 8'hFF;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
